interboard_msg_fifo: RTL and testbench

- Receive-side buffer directly downstream of the interboard communication top.
- Captures each one-pulse interboard_en message (move_dir, block_x, block_y, msg_type, card, sel_len) into a FIFO.
- Presents the oldest message to game control with a valid/pop handshake, so bursts from the other board are not lost while game control is busy.
- Flushes on the remote-reset indication and flags any overflow.

---
 rtl/interboard_msg_fifo_if.sv | 57 +++++
 rtl/interboard_msg_fifo.sv | 102 ++++++++++
 tb/tb_interboard_msg_fifo.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/interboard_msg_fifo_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | interboard_msg_fifo_if : message-in / head-out bundle of the message FIFO |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
interface interboard_msg_fifo_if #(
  parameter int ADDR_W = 2
);
  logic              interboard_rst;
  logic              interboard_en;
  logic              interboard_move_dir;
  logic [4:0]        interboard_block_x;
  logic [2:0]        interboard_block_y;
  logic [3:0]        interboard_msg_type;
  logic [5:0]        interboard_card;
  logic [2:0]        interboard_sel_len;
  logic              msg_pop;
  logic              ovf_clr;
  logic              msg_valid;
  logic              msg_move_dir;
  logic [4:0]        msg_block_x;
  logic [2:0]        msg_block_y;
  logic [3:0]        msg_type;
  logic [5:0]        msg_card;
  logic [2:0]        msg_sel_len;
  logic [ADDR_W:0]   msg_count;
  logic              fifo_full;
  logic              overflow;
`ifdef INTERBOARD_DROP_CNT_EN
  logic [7:0]        drop_cnt;
`endif

  // FIFO side
  modport slave (
    input  interboard_rst, interboard_en, interboard_move_dir, interboard_block_x,
           interboard_block_y, interboard_msg_type, interboard_card, interboard_sel_len,
           msg_pop, ovf_clr,
    output msg_valid, msg_move_dir, msg_block_x, msg_block_y, msg_type, msg_card,
           msg_sel_len, msg_count, fifo_full, overflow
`ifdef INTERBOARD_DROP_CNT_EN
           , drop_cnt
`endif
  );

  // Communication-top / game-control side
  modport master (
    output interboard_rst, interboard_en, interboard_move_dir, interboard_block_x,
           interboard_block_y, interboard_msg_type, interboard_card, interboard_sel_len,
           msg_pop, ovf_clr,
    input  msg_valid, msg_move_dir, msg_block_x, msg_block_y, msg_type, msg_card,
           msg_sel_len, msg_count, fifo_full, overflow
`ifdef INTERBOARD_DROP_CNT_EN
           , drop_cnt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/interboard_msg_fifo.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | interboard_msg_fifo : FWFT receive FIFO for interboard messages with a    |
// | drop-and-flag overflow policy. Optional INTERBOARD_DROP_CNT_EN adds an    |
// | 8-bit saturating dropped-message counter (drop_cnt).                      |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module interboard_msg_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  interboard_msg_fifo_if.slave  bus
);
  localparam int              ENTRY_W  = 22;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] head;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               do_push, do_pop, drop, wr_en;

  assign wr_data = {bus.interboard_move_dir, bus.interboard_block_x, bus.interboard_block_y,
                    bus.interboard_msg_type, bus.interboard_card, bus.interboard_sel_len};

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    do_pop     = bus.msg_pop && (count_q != '0);
    do_push    = bus.interboard_en && ((count_q != FULL_CNT) || do_pop);
    drop       = bus.interboard_en && !do_push;
    wr_en      = do_push && !bus.interboard_rst;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (bus.interboard_rst) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
      if (drop)             overflow_d = 1'b1;
      else if (bus.ovf_clr) overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only observable while counted.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign head = mem_q[rd_ptr_q];
  assign {bus.msg_move_dir, bus.msg_block_x, bus.msg_block_y,
          bus.msg_type, bus.msg_card, bus.msg_sel_len} = head;
  assign bus.msg_valid = (count_q != '0);
  assign bus.fifo_full = (count_q == FULL_CNT);
  assign bus.msg_count = count_q;
  assign bus.overflow  = overflow_q;

`ifdef INTERBOARD_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // A clear coinciding with a drop restarts the tally at one.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.interboard_rst)                drop_cnt_d = '0;
    else if (bus.ovf_clr)                  drop_cnt_d = drop ? 8'd1 : 8'd0;
    else if (drop && drop_cnt_q != 8'hFF)  drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign bus.drop_cnt = drop_cnt_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_interboard_msg_fifo.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_interboard_msg_fifo : directed + random bench with queue-based model   |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module tb_interboard_msg_fifo;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  interboard_msg_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  interboard_msg_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [21:0] mq[$];
  logic        m_ovf;
  int          m_dc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] mk(input int card);
    logic [31:0] c;
    c  = 32'(card);
    mk = {c[0], c[4:0], c[2:0], c[3:0], c[5:0], c[2:0]};
  endfunction

  task automatic check_state();
    chk("count", 32'(bus.msg_count), 32'(mq.size()));
    chk("valid", 32'(bus.msg_valid), 32'(mq.size() != 0));
    chk("full", 32'(bus.fifo_full), 32'(mq.size() == DEPTH));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
`ifdef INTERBOARD_DROP_CNT_EN
    chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_dc));
`endif
    if (mq.size() != 0)
      chk("head", 32'({bus.msg_move_dir, bus.msg_block_x, bus.msg_block_y,
                       bus.msg_type, bus.msg_card, bus.msg_sel_len}), 32'(mq[0]));
  endtask

  // One clock: drive inputs, advance the model, then sample after the edge.
  task automatic step(input logic en, input logic [21:0] d, input logic pop,
                      input logic clr, input logic irst);
    logic pop_ok, push_ok, dropped;
    bus.interboard_en       = en;
    {bus.interboard_move_dir, bus.interboard_block_x, bus.interboard_block_y,
     bus.interboard_msg_type, bus.interboard_card, bus.interboard_sel_len} = d;
    bus.msg_pop             = pop;
    bus.ovf_clr             = clr;
    bus.interboard_rst      = irst;
    if (irst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_dc  = 0;
    end else begin
      pop_ok  = pop && (mq.size() > 0);
      push_ok = en && ((mq.size() < DEPTH) || pop_ok);
      dropped = en && !push_ok;
      if (pop_ok)  void'(mq.pop_front());
      if (push_ok) mq.push_back(d);
      if (dropped) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (clr) m_dc = dropped ? 1 : 0;
      else if (dropped && m_dc < 255) m_dc++;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic push(input int card);
    step(1'b1, mk(card), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_expect(input int card);
    chk("pop_order", 32'(bus.msg_card), 32'(card));
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.interboard_en = 1'b0; bus.msg_pop = 1'b0; bus.ovf_clr = 1'b0;
    bus.interboard_rst = 1'b0;
    {bus.interboard_move_dir, bus.interboard_block_x, bus.interboard_block_y,
     bus.interboard_msg_type, bus.interboard_card, bus.interboard_sel_len} = '0;
    m_ovf = 1'b0;
    m_dc  = 0;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_state();

    // Single message
    step(1'b1, {1'b1, 5'd17, 3'd4, 4'hA, 6'd33, 3'd2}, 1'b0, 1'b0, 1'b0);
    chk("single_bx", 32'(bus.msg_block_x), 32'd17);
    chk("single_card", 32'(bus.msg_card), 32'd33);
    chk("single_type", 32'(bus.msg_type), 32'hA);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Fill, drop, drain, wrap
    for (int c = 1; c <= 4; c++) push(c);
    chk("fill_full", 32'(bus.fifo_full), 32'd1);
    push(5);
    chk("drop_ovf", 32'(bus.overflow), 32'd1);
    for (int c = 1; c <= 4; c++) pop_expect(c);
    for (int c = 6; c <= 8; c++) push(c);
    for (int c = 6; c <= 8; c++) pop_expect(c);

    // Full with simultaneous push and pop
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 4; c++) push(c);
    step(1'b1, mk(9), 1'b1, 1'b0, 1'b0);
    chk("pp_full_count", 32'(bus.msg_count), 32'd4);
    for (int c = 2; c <= 4; c++) pop_expect(c);
    pop_expect(9);

    // Empty pop, empty push+pop
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, mk(7), 1'b1, 1'b0, 1'b0);
    chk("pp_empty_card", 32'(bus.msg_card), 32'd7);
    pop_expect(7);

    // Clear coinciding with a drop keeps overflow set
    for (int c = 1; c <= 4; c++) push(c);
    step(1'b1, mk(20), 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Remote flush mid-burst with overflow set
    push(21);
    pop_expect(1);
    chk("pre_flush_count", 32'(bus.msg_count), 32'd3);
    step(1'b1, mk(10), 1'b0, 1'b0, 1'b1);
    chk("flush_count", 32'(bus.msg_count), 32'd0);
    push(11);
    chk("post_flush_card", 32'(bus.msg_card), 32'd11);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic en, pop, clr, irst;
      en   = ($urandom % 4) < ((i / 150) % 2 == 0 ? 3 : 1);
      pop  = ($urandom % 4) < ((i / 150) % 2 == 0 ? 1 : 3);
      clr  = ($urandom % 16) == 0;
      irst = ($urandom % 60) == 0;
      step(en, 22'($urandom), pop, clr, irst);
    end

    // Long drop run exercises the counter saturation
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) push(c);
    for (int i = 0; i < 260; i++) push(i);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
